// File: rtl/tamagotchi_input_ctrl_pkg.sv
// Shared definitions for the Tamagotchi input front end.
// The test FSM states and test codes live here, alongside the pet-state codes that the test codes select.
package tamagotchi_input_ctrl_pkg;

   typedef enum logic [1:0] {
      T_IDLE   = 2'd0,
      T_ARM    = 2'd1,
      T_SELECT = 2'd2,
      T_HOLD   = 2'd3
   } test_state_t;

   localparam logic [3:0] TEST_CODE_NONE = 4'd0;
   localparam logic [3:0] TEST_CODE_MAX  = 4'd9;

   // A non-zero pulse_test value forces the pet FSM straight into the matching state.
   typedef enum logic [3:0] {
      PET_NONE     = 4'd0,
      PET_NEUTRAL  = 4'd1,
      PET_HUNGRY   = 4'd2,
      PET_EATING   = 4'd3,
      PET_TIRED    = 4'd4,
      PET_SLEEPING = 4'd5,
      PET_BORED    = 4'd6,
      PET_PLAYING  = 4'd7,
      PET_SICK     = 4'd8,
      PET_DEAD     = 4'd9
   } pet_state_t;

   function automatic logic [3:0] next_code(input logic [3:0] code);
      return (code == TEST_CODE_MAX) ? 4'd1 : code + 4'd1;
   endfunction

endpackage

// File: rtl/tamagotchi_input_ctrl_debounce.sv
// Two-flop synchroniser followed by a stability counter.
// The level only changes after DEB_CYCLES consecutive samples disagree with it.
module button_debounce #(
   parameter int DEB_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level
);

   localparam int CW = $clog2(DEB_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/tamagotchi_input_ctrl.sv
// Button/tilt front end for the pet FSM: debouncing, command masking and the test-code entry protocol.
module tamagotchi_input_ctrl
   import tamagotchi_input_ctrl_pkg::*;
#(
   parameter int DEB_CYCLES  = 500000,
   parameter int LONG_CYCLES = 250000000,
   parameter int HOLD_CYCLES = 200000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_sleep_n,
   input  logic       btn_awake_n,
   input  logic       btn_feed_n,
   input  logic       btn_play_n,
   input  logic       btn_test_n,
   input  logic       btn_sel_n,
   input  logic       tilt_in,
   output logic       sleep,
   output logic       awake,
   output logic       feed,
   output logic       play,
   output logic       giro,
   output logic       test_mode,
   output logic [3:0] pulse_test
);

   localparam int LW = $clog2(LONG_CYCLES) + 1;
   localparam int HW = $clog2(HOLD_CYCLES) + 1;
   localparam int SETTLE = DEB_CYCLES + 2;
   localparam int SW = $clog2(SETTLE) + 1;
   localparam logic [LW-1:0] LONG_MAX   = LW'(LONG_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_CYCLES - 1);
   localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE);

   logic [6:0]    raw_in;
   logic [6:0]    lvl;
   logic [SW-1:0] settle_cnt;
   logic          settled;
   logic          test_prev;
   logic          sel_prev;
   logic          test_rise;
   logic          sel_rise;
   logic          masked;

   test_state_t   state, state_nx;
   logic [LW-1:0] long_cnt, long_nx;
   logic [HW-1:0] hold_cnt, hold_nx;
   logic [3:0]    pulse_nx;

   assign raw_in = {tilt_in, ~btn_sel_n, ~btn_test_n, ~btn_play_n,
                    ~btn_feed_n, ~btn_awake_n, ~btn_sleep_n};

   for (genvar i = 0; i < 7; i++) begin : g_deb
      button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .clk   (clk),
         .rst   (rst),
         .raw   (raw_in[i]),
         .level (lvl[i])
      );
   end

   // Until the debouncers have had time to see a button held across reset, the previous
   // level is pinned high so that such a button never looks like a fresh press.
   assign settled = (settle_cnt == SETTLE_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         settle_cnt <= '0;
         test_prev  <= 1'b1;
         sel_prev   <= 1'b1;
      end else begin
         if (!settled) begin
            settle_cnt <= settle_cnt + 1'b1;
            test_prev  <= 1'b1;
            sel_prev   <= 1'b1;
         end else begin
            test_prev <= lvl[4];
            sel_prev  <= lvl[5];
         end
      end
   end

   assign test_rise = lvl[4] & ~test_prev;
   assign sel_rise  = lvl[5] & ~sel_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= T_IDLE;
         long_cnt   <= '0;
         hold_cnt   <= '0;
         pulse_test <= TEST_CODE_NONE;
      end else begin
         state      <= state_nx;
         long_cnt   <= long_nx;
         hold_cnt   <= hold_nx;
         pulse_test <= pulse_nx;
      end
   end

   // In T_SELECT the select increment is resolved before the exit test, so a
   // simultaneous test press leaves with the freshly incremented code.
   always_comb begin
      state_nx = state;
      long_nx  = long_cnt;
      hold_nx  = hold_cnt;
      pulse_nx = pulse_test;
      case (state)
         T_IDLE: begin
            if (test_rise) begin
               state_nx = T_ARM;
               long_nx  = '0;
            end
         end
         T_ARM: begin
            if (!lvl[4]) begin
               state_nx = T_IDLE;
            end else if (long_cnt == LONG_MAX) begin
               state_nx = T_SELECT;
               pulse_nx = TEST_CODE_NONE;
            end else begin
               long_nx = long_cnt + 1'b1;
            end
         end
         T_SELECT: begin
            if (sel_rise) begin
               pulse_nx = next_code(pulse_test);
            end
            if (test_rise && (pulse_nx != TEST_CODE_NONE)) begin
               state_nx = T_HOLD;
               hold_nx  = '0;
            end
         end
         T_HOLD: begin
            if (hold_cnt == HOLD_MAX) begin
               state_nx = T_IDLE;
               pulse_nx = TEST_CODE_NONE;
            end else begin
               hold_nx = hold_cnt + 1'b1;
            end
         end
         default: state_nx = T_IDLE;
      endcase
   end

   assign masked    = (state == T_SELECT) || (state == T_HOLD);
   assign test_mode = (state == T_SELECT);
   assign sleep     = lvl[0] & ~masked;
   assign awake     = lvl[1] & ~masked;
   assign feed      = lvl[2] & ~masked;
   assign play      = lvl[3] & ~masked;
   assign giro      = lvl[6];

endmodule

// File: tb/tb_tamagotchi_input_ctrl.sv
// Bench for tamagotchi_input_ctrl: a cycle-level reference model checked every cycle,
// plus directed scenarios with hand-computed timing expectations.
module tb_tamagotchi_input_ctrl;

   localparam int DEB  = 4;
   localparam int LONG = 20;
   localparam int HOLD = 10;

   localparam int M_IDLE   = 0;
   localparam int M_ARM    = 1;
   localparam int M_SELECT = 2;
   localparam int M_HOLD   = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_sleep_n = 1'b1;
   logic       btn_awake_n = 1'b1;
   logic       btn_feed_n  = 1'b1;
   logic       btn_play_n  = 1'b1;
   logic       btn_test_n  = 1'b1;
   logic       btn_sel_n   = 1'b1;
   logic       tilt_in     = 1'b0;
   logic       sleep, awake, feed, play, giro, test_mode;
   logic [3:0] pulse_test;

   int   checks = 0;
   int   errors = 0;
   logic cmp_en = 1'b0;

   always #5 clk = ~clk;

   tamagotchi_input_ctrl #(
      .DEB_CYCLES  (DEB),
      .LONG_CYCLES (LONG),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_sleep_n (btn_sleep_n),
      .btn_awake_n (btn_awake_n),
      .btn_feed_n  (btn_feed_n),
      .btn_play_n  (btn_play_n),
      .btn_test_n  (btn_test_n),
      .btn_sel_n   (btn_sel_n),
      .tilt_in     (tilt_in),
      .sleep       (sleep),
      .awake       (awake),
      .feed        (feed),
      .play        (play),
      .giro        (giro),
      .test_mode   (test_mode),
      .pulse_test  (pulse_test)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic setButton(input int idx, input logic pressed);
      case (idx)
         0: btn_sleep_n = !pressed;
         1: btn_awake_n = !pressed;
         2: btn_feed_n  = !pressed;
         3: btn_play_n  = !pressed;
         4: btn_test_n  = !pressed;
         5: btn_sel_n   = !pressed;
         default: tilt_in = pressed;
      endcase
   endtask

   task automatic applyStimulus(input int idx, input int low_cycles, input int high_cycles);
      setButton(idx, 1'b1);
      repeat (low_cycles) @(negedge clk);
      setButton(idx, 1'b0);
      repeat (high_cycles) @(negedge clk);
   endtask

   // Reference model: a level flips once the last DEB synchronised samples (two edges old
   // and older) all disagree with it; presses only count once the level was seen released.
   logic [6:0] raw_now;
   assign raw_now = {tilt_in, !btn_sel_n, !btn_test_n, !btn_play_n,
                     !btn_feed_n, !btn_awake_n, !btn_sleep_n};

   logic hist [7][DEB+2];
   logic m_lvl [7];
   logic m_rise_test, m_rise_sel;
   int   m_mode, m_code, edge_cnt, arm_t, hold_t;

   always begin : model
      logic prev_test, prev_sel, all_diff;
      @(posedge clk or posedge rst);
      if (rst) begin
         for (int i = 0; i < 7; i++) begin
            m_lvl[i] = 1'b0;
            for (int j = 0; j < DEB + 2; j++) hist[i][j] = 1'b0;
         end
         m_rise_test = 1'b0;
         m_rise_sel  = 1'b0;
         m_mode      = M_IDLE;
         m_code      = 0;
         edge_cnt    = 0;
         arm_t       = 0;
         hold_t      = 0;
      end else begin
         edge_cnt++;
         case (m_mode)
            M_IDLE: if (m_rise_test) begin
               m_mode = M_ARM;
               arm_t  = edge_cnt;
            end
            M_ARM: if (!m_lvl[4]) m_mode = M_IDLE;
               else if (edge_cnt - arm_t == LONG) begin
                  m_mode = M_SELECT;
                  m_code = 0;
               end
            M_SELECT: begin
               if (m_rise_sel) m_code = (m_code == 9) ? 1 : m_code + 1;
               if (m_rise_test && m_code != 0) begin
                  m_mode = M_HOLD;
                  hold_t = edge_cnt;
               end
            end
            default: if (edge_cnt - hold_t == HOLD) begin
               m_mode = M_IDLE;
               m_code = 0;
            end
         endcase
         prev_test = m_lvl[4];
         prev_sel  = m_lvl[5];
         for (int i = 0; i < 7; i++) begin
            for (int j = DEB + 1; j > 0; j--) hist[i][j] = hist[i][j-1];
            hist[i][0] = raw_now[i];
            all_diff = 1'b1;
            for (int j = 2; j <= DEB + 1; j++) if (hist[i][j] == m_lvl[i]) all_diff = 1'b0;
            if (all_diff) m_lvl[i] = !m_lvl[i];
         end
         m_rise_test = m_lvl[4] && !prev_test && (edge_cnt >= DEB + 3);
         m_rise_sel  = m_lvl[5] && !prev_sel  && (edge_cnt >= DEB + 3);
      end
   end

   always begin : compare
      logic cmd_on;
      @(negedge clk);
      if (cmp_en) begin
         cmd_on = (m_mode == M_IDLE) || (m_mode == M_ARM);
         checkOutput("model_sleep", sleep, m_lvl[0] && cmd_on);
         checkOutput("model_awake", awake, m_lvl[1] && cmd_on);
         checkOutput("model_feed",  feed,  m_lvl[2] && cmd_on);
         checkOutput("model_play",  play,  m_lvl[3] && cmd_on);
         checkOutput("model_giro",  giro,  m_lvl[6]);
         checkOutput("model_test_mode", test_mode, m_mode == M_SELECT);
         checkOutput("model_pulse_test", pulse_test, m_code);
      end
   end

   initial begin
      int glitches, lat, tm_at, drop_at, hold_len;

      repeat (2) @(negedge clk);
      checkOutput("reset_test_mode", test_mode, 0);
      checkOutput("reset_pulse_test", pulse_test, 0);
      checkOutput("reset_feed", feed, 0);
      rst    = 1'b0;
      cmp_en = 1'b1;
      repeat (10) @(negedge clk);

      // 1: bouncing feed, then held
      glitches = 0;
      for (int t = 0; t < 10; t++) begin
         btn_feed_n = !btn_feed_n;
         repeat (2) begin
            @(negedge clk);
            if (feed) glitches++;
         end
      end
      btn_feed_n = 1'b0;
      lat = -1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (feed && lat < 0) lat = i;
      end
      checkOutput("bounce_glitches", glitches, 0);
      checkOutput("bounce_latency", lat, 6);

      // 2: short test press has no effect
      btn_play_n = 1'b0;
      tilt_in    = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("giro_on", giro, 1);
      checkOutput("play_pass", play, 1);
      btn_test_n = 1'b0;
      repeat (15) @(negedge clk);
      btn_test_n = 1'b1;
      repeat (30) @(negedge clk);
      checkOutput("short_press_test_mode", test_mode, 0);
      checkOutput("short_press_play", play, 1);
      checkOutput("short_press_feed", feed, 1);
      btn_play_n = 1'b1;
      btn_feed_n = 1'b1;
      repeat (10) @(negedge clk);

      // 3: long press, code 3, exit and hold window
      btn_test_n = 1'b0;
      tm_at = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (test_mode && tm_at < 0) tm_at = i;
      end
      checkOutput("arm_latency", tm_at, 27);
      btn_test_n = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("giro_unmasked", giro, 1);
      for (int p = 0; p < 3; p++) applyStimulus(5, 8, 8);
      checkOutput("code_after_3", pulse_test, 3);
      btn_test_n = 1'b0;
      drop_at  = -1;
      hold_len = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (!test_mode && drop_at < 0) drop_at = i;
         if (!test_mode && pulse_test == 4'd3) hold_len++;
      end
      checkOutput("exit_latency", drop_at, 7);
      checkOutput("hold_length", hold_len, 10);
      checkOutput("code_cleared", pulse_test, 0);
      btn_test_n = 1'b1;
      repeat (10) @(negedge clk);

      // 5: re-enter; test press with code 0 ignored, feed masked
      btn_test_n = 1'b0;
      repeat (30) @(negedge clk);
      btn_test_n = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("reenter_test_mode", test_mode, 1);
      applyStimulus(4, 8, 8);
      checkOutput("zero_code_exit_ignored", test_mode, 1);
      btn_feed_n = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("feed_masked", feed, 0);
      btn_feed_n = 1'b1;
      repeat (8) @(negedge clk);

      // 4: code wraps 9 -> 1
      for (int p = 0; p < 10; p++) begin
         applyStimulus(5, 8, 8);
         checkOutput($sformatf("code_step_%0d", p), pulse_test, (p % 9) + 1);
      end
      for (int p = 0; p < 4; p++) applyStimulus(5, 8, 8);
      checkOutput("code_5", pulse_test, 5);

      // 6: reset mid-select with buttons held
      btn_test_n = 1'b0;
      btn_feed_n = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_sleep", sleep, 0);
      checkOutput("rst_awake", awake, 0);
      checkOutput("rst_feed", feed, 0);
      checkOutput("rst_play", play, 0);
      checkOutput("rst_giro", giro, 0);
      checkOutput("rst_test_mode", test_mode, 0);
      checkOutput("rst_pulse_test", pulse_test, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      checkOutput("held_test_no_rearm", test_mode, 0);
      checkOutput("held_feed_passes", feed, 1);
      btn_test_n = 1'b1;
      repeat (10) @(negedge clk);
      btn_test_n = 1'b0;
      repeat (30) @(negedge clk);
      checkOutput("repress_arms", test_mode, 1);
      btn_test_n = 1'b1;
      btn_feed_n = 1'b1;
      repeat (10) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
